// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// clear/run state encoding and the default geometry used by the pipeline top.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Combinational write-port priority resolve and per-read-port bypass lookup.
// Lower write port index wins when enabled ports share an address.
module regfile_wr_arb #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NWRITE-1:0]       win_en,
  output logic [NREAD-1:0]        bp_hit,
  output logic [NREAD*WIDTH-1:0]  bp_data
);

  genvar gi;

  for (gi = 0; gi < NWRITE; gi++) begin : g_win
    logic shadowed;
    logic zero_drop;

    // A port loses if any lower-indexed enabled port targets the same entry.
    always_comb begin
      shadowed = 1'b0;
      for (int q = 0; q < gi; q++) begin
        if (wen[q] && (waddr[q*AW +: AW] == waddr[gi*AW +: AW])) begin
          shadowed = 1'b1;
        end
      end
    end

    assign zero_drop   = (ZERO_REG != 0) && (waddr[gi*AW +: AW] == '0);
    assign win_en[gi]  = wen[gi] && !shadowed && !zero_drop;
  end

  for (gi = 0; gi < NREAD; gi++) begin : g_bp
    logic             hit_next;
    logic [WIDTH-1:0] data_next;

    // Winners have distinct addresses, so at most one can match.
    always_comb begin
      hit_next  = 1'b0;
      data_next = '0;
      for (int p = 0; p < NWRITE; p++) begin
        if (win_en[p] && (waddr[p*AW +: AW] == raddr[gi*AW +: AW])) begin
          hit_next  = 1'b1;
          data_next = wdata[p*WIDTH +: WIDTH];
        end
      end
    end

    assign bp_hit[gi]                  = hit_next;
    assign bp_data[gi*WIDTH +: WIDTH]  = data_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset clear sweep,
// optional write-to-read bypass and stall hold of the registered read data.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RET_REG  = 3,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*WIDTH-1:0]  rdata,
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  input  logic                    stall,
  output logic                    ready,
  output logic [WIDTH-1:0]        ret_val
);

  genvar gi;

  state_t           state_reg, state_next;
  logic [AW-1:0]    clr_ptr_reg, clr_ptr_next;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [NWRITE-1:0]      win_en;
  logic [NREAD-1:0]       bp_hit;
  logic [NREAD*WIDTH-1:0] bp_data;

  regfile_wr_arb #(
    .WIDTH    (WIDTH),
    .AW       (AW),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG)
  ) u_wr_arb (
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .win_en  (win_en),
    .bp_hit  (bp_hit),
    .bp_data (bp_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    if (state_reg == ST_CLEAR) begin
      clr_ptr_next = clr_ptr_reg + AW'(1);
      if (clr_ptr_reg == AW'(DEPTH - 1)) begin
        state_next = ST_RUN;
      end
    end
  end

  assign ready = (state_reg == ST_RUN);

  // The array has no reset; the sweep is what makes its contents defined.
  always_ff @(posedge clk) begin
    if (state_reg == ST_CLEAR) begin
      mem[clr_ptr_reg] <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (win_en[p]) begin
          mem[waddr[p*AW +: AW]] <= wdata[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd_reg, rd_next;

    assign ra = raddr[gi*AW +: AW];

    always_comb begin
      rd_next = rd_reg;
      if (state_reg == ST_CLEAR) begin
        rd_next = '0;
      end else if (!stall) begin
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd_next = '0;
        end else if ((BYPASS != 0) && bp_hit[gi]) begin
          rd_next = bp_data[gi*WIDTH +: WIDTH];
        end else begin
          rd_next = mem[ra];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_reg <= '0;
      end else begin
        rd_reg <= rd_next;
      end
    end

    assign rdata[gi*WIDTH +: WIDTH] = rd_reg;
  end

  assign ret_val = mem[AW'(RET_REG)];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus and are
// compared against an array-level reference model, directed steps then random.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NW-1:0]    wen   = '0;
  logic [NW*AW-1:0] waddr = '0;
  logic [NW*W-1:0]  wdata = '0;

  logic [NR*W-1:0] rdata_bp, rdata_nb;
  logic            ready_bp, ready_nb;
  logic [W-1:0]    ret_bp, ret_nb;

  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_rd_bp [NR];
  logic [W-1:0] m_rd_nb [NR];
  logic         m_ready = 1'b0;
  int           m_clr_left = D;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW),
    .ZERO_REG(1), .BYPASS(1), .RET_REG(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_bp),
    .wen(wen), .waddr(waddr), .wdata(wdata), .stall(stall),
    .ready(ready_bp), .ret_val(ret_bp)
  );

  regfile_mp #(
    .WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW),
    .ZERO_REG(1), .BYPASS(0), .RET_REG(3)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb),
    .wen(wen), .waddr(waddr), .wdata(wdata), .stall(stall),
    .ready(ready_nb), .ret_val(ret_nb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " ready_bp"}, 64'(ready_bp), 64'(m_ready));
    check({tag, " ready_nb"}, 64'(ready_nb), 64'(m_ready));
    for (int r = 0; r < NR; r++) begin
      check($sformatf("%s rdata_bp[%0d]", tag, r), 64'(rdata_bp[r*W +: W]), 64'(m_rd_bp[r]));
      check($sformatf("%s rdata_nb[%0d]", tag, r), 64'(rdata_nb[r*W +: W]), 64'(m_rd_nb[r]));
    end
    if (m_ready) begin
      check({tag, " ret_bp"}, 64'(ret_bp), 64'(m_mem[3]));
      check({tag, " ret_nb"}, 64'(ret_nb), 64'(m_mem[3]));
    end
  endtask

  task automatic model_reset();
    m_ready    = 1'b0;
    m_clr_left = D;
    for (int r = 0; r < NR; r++) begin
      m_rd_bp[r] = '0;
      m_rd_nb[r] = '0;
    end
  endtask

  // One clock edge: the model applies the behavioural rules to the inputs
  // present at the edge, then both instances are compared shortly after it.
  task automatic step(input string tag);
    logic [W-1:0] new_mem [D];
    logic [AW-1:0] a;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_clr_left > 0) begin
      for (int r = 0; r < NR; r++) begin
        m_rd_bp[r] = '0;
        m_rd_nb[r] = '0;
      end
      m_clr_left--;
      if (m_clr_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
      end
    end else begin
      new_mem = m_mem;
      // Apply highest port first so lower ports overwrite it: lowest index wins.
      for (int p = NW - 1; p >= 0; p--) begin
        a = waddr[p*AW +: AW];
        if (wen[p] && a != 0) new_mem[a] = wdata[p*W +: W];
      end
      if (!stall) begin
        for (int r = 0; r < NR; r++) begin
          a = raddr[r*AW +: AW];
          m_rd_bp[r] = (a == 0) ? '0 : new_mem[a];
          m_rd_nb[r] = (a == 0) ? '0 : m_mem[a];
        end
      end
      m_mem = new_mem;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic set_wr(input int p, input logic en, input int a, input logic [W-1:0] d);
    logic [AW-1:0] a5;
    a5 = AW'(a);
    wen[p]            = en;
    waddr[p*AW +: AW] = a5;
    wdata[p*W +: W]   = d;
  endtask

  task automatic set_rd(input int r, input int a);
    logic [AW-1:0] a5;
    a5 = AW'(a);
    raddr[r*AW +: AW] = a5;
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    model_reset();

    // Reset held, then release with writes attempted during the sweep.
    repeat (3) step("reset");
    rst_n = 1'b1;
    set_wr(0, 1'b1, 5, 32'hDEAD_0005);
    set_wr(1, 1'b1, 6, 32'hDEAD_0006);
    set_rd(0, 5);
    set_rd(1, 6);
    for (int k = 0; k < D; k++) step("clear");
    wen = '0;
    step("post_clear_read");

    // Same-address priority, then distinct addresses both commit.
    set_wr(0, 1'b1, 7, 32'hAAAA_0000);
    set_wr(1, 1'b1, 7, 32'h0000_5555);
    set_rd(0, 7);
    set_rd(1, 1);
    step("prio_same_addr");
    wen = '0;
    step("prio_readback");
    set_wr(0, 1'b1, 7, 32'h1111_2222);
    set_wr(1, 1'b1, 8, 32'h3333_4444);
    step("two_addr_write");
    wen = '0;
    set_rd(1, 8);
    step("two_addr_readback");

    // Same-cycle write and read of r4: bypass vs pre-write value.
    set_wr(0, 1'b1, 4, 32'h1234_5678);
    set_rd(0, 4);
    step("bypass_r4");
    wen = '0;
    step("r4_settled");

    // Register 0 ignores writes, also on the bypass path.
    set_wr(0, 1'b1, 0, 32'hFFFF_FFFF);
    set_wr(1, 1'b1, 0, 32'hFFFF_FFFF);
    set_rd(0, 0);
    set_rd(1, 0);
    step("zero_bypass");
    wen = '0;
    step("zero_readback");

    // Stall freezes rdata while writes still land.
    set_rd(0, 7);
    set_rd(1, 8);
    step("pre_stall");
    stall = 1'b1;
    set_wr(0, 1'b1, 9, 32'h0000_BEEF);
    set_rd(0, 4);
    set_rd(1, 9);
    step("stall_1");
    wen = '0;
    set_rd(0, 2);
    step("stall_2");
    set_rd(1, 9);
    step("stall_3");
    stall = 1'b0;
    step("stall_release");

    // ret_val, then an asynchronous reset mid-run and a fresh sweep.
    set_wr(0, 1'b1, 3, 32'd42);
    step("ret_write");
    wen = '0;
    step("ret_hold");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    step("reset_held");
    rst_n = 1'b1;
    for (int k = 0; k < D; k++) step("resweep");
    set_rd(0, 3);
    step("after_resweep");

    // Random traffic with a narrow address range to provoke collisions.
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NW; p++) begin
        set_wr(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
      end
      for (int r = 0; r < NR; r++) set_rd(r, int'($urandom_range(0, 7)));
      stall = ($urandom_range(0, 4) == 0);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the fixed 2-read/2-write core regfile. It adds configurable width, depth and port counts, optional same-cycle write-to-read bypass, and a working stall hold. Because the array itself has no reset, a post-reset clear sequencer zeroes every entry before the file reports ready. It sits in the decode stage of the pipelines, with its read data feeding the execute stage.

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers; power of 2, at least 2
NREAD, 2, number of read ports, 1..4
NWRITE, 2, number of write ports, 1..4; lower index has higher priority
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a read sees a write to the same address in the same cycle
RET_REG, 3, register index exposed on ret_val

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
raddr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW]; AW = $clog2(DEPTH)
rdata  out  NREAD*WIDTH  registered read data, port i in slice i
wen  in  NWRITE  per-port write enable
waddr  in  NWRITE*AW  write addresses, one slice per port
wdata  in  NWRITE*WIDTH  write data, one slice per port
stall  in  1  hold rdata; writes still proceed
ready  out  1  high once the clear sweep has finished
ret_val  out  WIDTH  combinational value of array[RET_REG], for test

Behaviour:
- Reset (rst_n low, asynchronous): rdata = 0, ready = 0, state = CLEAR, clr_ptr = 0. The array is not reset directly.
- States:
  - CLEAR: each cycle writes 0 to array[clr_ptr] and increments clr_ptr. In the cycle where clr_ptr == DEPTH-1, the next state is RUN and ready rises on that same edge. The sweep takes exactly DEPTH cycles after rst_n deasserts.
  - RUN: terminal state; only rst_n leaves it.
- During CLEAR:
  - all wen are ignored;
  - rdata is forced to 0 on every edge;
  - stall has no effect.
- Writes in RUN:
  - each port with wen high writes wdata to waddr on the edge;
  - if several enabled ports share an address, the lowest port index wins and the others are dropped for that address;
  - if ZERO_REG = 1, writes to address 0 are discarded.
- Reads in RUN:
  - 1-cycle latency: rdata[i] is updated on the edge from raddr[i] sampled at that edge;
  - ZERO_REG = 1 and raddr = 0 gives rdata 0, even with bypass;
  - BYPASS = 1 with a same-cycle winning write to raddr: rdata takes that write's wdata;
  - BYPASS = 0: rdata takes the pre-write array value.
- Stall in RUN: rdata holds its previous value and raddr is ignored. Writes still commit. When stall drops, the next edge reads the updated array.
- Reset mid-sweep or mid-run: ready falls immediately and the sweep restarts from entry 0. Array contents are indeterminate until the new sweep completes.
- ret_val has no bypass; it reflects committed array contents only.
- Widths: addresses are AW bits, so out-of-range addresses are impossible. All data paths are WIDTH bits with no extension.

Decomposition:
- Shared package regfile_pkg holds:
  - the clog2-based AW helper;
  - the state encoding (ST_CLEAR = 1'b0, ST_RUN = 1'b1);
  - default WIDTH/DEPTH constants shared with the pipeline top.
- Sub-module regfile_wr_arb: combinational per-address priority resolve producing the winning enable/data per port, plus the bypass hit/data per read port. It is instantiated once.
- The clear FSM and array stay in regfile_mp.

Test Plan:
All scenarios use default parameters.
1. Reset release → ready stays 0 for 32 cycles then 1; reading r5 afterwards → rdata 0; wen asserted during CLEAR → no effect, reads still 0 after ready.
2. Same-edge wen0 and wen1 to r7, wdata0 = 0xAAAA0000, wdata1 = 0x5555 → r7 = 0xAAAA0000; port 1 to r8 with port 0 to r7 → both commit.
3. Write r4 = 0x12345678 and raddr0 = 4 in the same cycle → rdata0 = 0x12345678 next cycle. Repeat with BYPASS = 0 → old value 0.
4. Write r0 = 0xFFFFFFFF → raddr0 = 0 reads 0, including the bypass path.
5. stall = 1 for 3 cycles while raddr changes and r9 is written with 0xBEEF → rdata frozen; after stall drops, raddr1 = 9 → rdata1 = 0xBEEF.
6. Write r3 = 42 → ret_val = 42 after the edge. Pulse rst_n mid-run → ready = 0 at once, a 32-cycle sweep follows, then ret_val = 0.
